// File: rtl/period_stream_mux.sv
`default_nettype none
// ============================================================================
// Module      : period_stream_mux
// Description : Period-ordered merge of NBLOCKS block event streams and one
//               time-tag stream onto a single registered output. Blocks are
//               arbitrated by fixed priority or round-robin, and every output
//               word carries a source-index tag.
// Revision    : 1.0 - initial release
// ============================================================================
module period_stream_mux #(
    parameter int NBLOCKS  = 4,
    parameter int DATA_W   = 128,
    parameter int PERIOD_W = 48,
    parameter int RR_MODE  = 0,
    parameter int SRC_W    = $clog2(NBLOCKS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NBLOCKS-1:0]           blk_valid,
    input  logic [NBLOCKS*PERIOD_W-1:0]  blk_period,
    input  logic [NBLOCKS*DATA_W-1:0]    blk_data,
    output logic [NBLOCKS-1:0]           blk_ready,
    input  logic                         tt_valid,
    input  logic [PERIOD_W-1:0]          tt_period,
    input  logic [DATA_W-1:0]            tt_data,
    output logic                         tt_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    output logic [SRC_W-1:0]             out_src,
    input  logic                         out_ready
);

    // Pointer width; a single-block build still needs a one-bit vector.
    localparam int c_ptr_w = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;

    logic [NBLOCKS-1:0]  w_elig;
    logic [NBLOCKS-1:0]  w_blk_grant;
    logic                w_any_blk;
    logic                w_tt_grant;
    logic                w_load;
    logic [c_ptr_w-1:0]  w_base;
    logic [c_ptr_w:0]    w_sum;
    logic [c_ptr_w-1:0]  w_grant_idx;
    logic [c_ptr_w-1:0]  w_ptr_next;
    logic [DATA_W-1:0]   w_sel_data;
    logic [SRC_W-1:0]    w_sel_src;

    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic [SRC_W-1:0]    r_out_src;
    logic [c_ptr_w-1:0]  r_rr_ptr;

    // A block may go only if its period is strictly earlier than a waiting
    // time tag; equal periods let the time tag go first.
    generate
        for (genvar gi = 0; gi < NBLOCKS; gi++) begin : g_elig
            assign w_elig[gi] = blk_valid[gi] &
                (~tt_valid | (blk_period[gi*PERIOD_W +: PERIOD_W] < tt_period));
        end
    endgenerate

    // Fixed priority is round-robin searching from index 0.
    assign w_base = (RR_MODE != 0) ? r_rr_ptr : '0;

    // Block arbitration: first eligible index at or after the search base.
    always_comb begin
        w_any_blk   = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_blk_grant = '0;
        for (int k = 0; k < NBLOCKS; k++) begin
            w_sum = {1'b0, w_base} + (c_ptr_w+1)'(k);
            if (w_sum >= (c_ptr_w+1)'(NBLOCKS)) begin
                w_sum = w_sum - (c_ptr_w+1)'(NBLOCKS);
            end
            if (!w_any_blk && w_elig[w_sum[c_ptr_w-1:0]]) begin
                w_any_blk   = 1'b1;
                w_grant_idx = w_sum[c_ptr_w-1:0];
            end
        end
        if (w_any_blk) begin
            w_blk_grant[w_grant_idx] = 1'b1;
        end
    end

    assign w_tt_grant = tt_valid & ~w_any_blk;

    // Nothing is accepted while reset is held, so no input is lost then.
    assign w_load = rst_n & (~r_out_valid | out_ready);

    assign blk_ready = w_load ? w_blk_grant : '0;
    assign tt_ready  = w_load & w_tt_grant;

    assign w_ptr_next = (w_grant_idx == c_ptr_w'(NBLOCKS - 1)) ? '0 : w_grant_idx + 1'b1;

    // Select the word and source tag of the granted channel.
    always_comb begin
        w_sel_data = '0;
        w_sel_src  = '0;
        if (w_any_blk) begin
            for (int i = 0; i < NBLOCKS; i++) begin
                if (w_blk_grant[i]) begin
                    w_sel_data = blk_data[i*DATA_W +: DATA_W];
                end
            end
            w_sel_src = SRC_W'(w_grant_idx);
        end else begin
            w_sel_data = tt_data;
            w_sel_src  = SRC_W'(NBLOCKS);
        end
    end

    // Output register: load on a grant, drain to empty otherwise; held on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
        end else if (w_load) begin
            if (w_any_blk || w_tt_grant) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_src   <= w_sel_src;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves past each granted block; time tags leave it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if ((RR_MODE != 0) && w_load && w_any_blk) begin
            r_rr_ptr <= w_ptr_next;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;

endmodule
`default_nettype wire
